// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-side round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int PUSH_CNT_W = 16;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Rotating-priority picker: first set request searching upward from last_id+1.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic found;
  int   idx;

  // The previous owner sits at the lowest priority, so it re-wins only when alone.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_id) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin owner of a FIFO push port; define FIFO_ARB_BURST_EN to hold a
// grant for up to MAX_BURST accepted beats instead of releasing after each beat.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_push,
  output logic [DATA_W-1:0]           fifo_data,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic [PUSH_CNT_W-1:0]       push_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_push_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("fifo_push_arbiter: MAX_BURST must be 1..15");
  end

  arb_state_t      state;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] winner;
  logic            any_valid;
  logic            beat;
  logic            last_beat;
  logic            release_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req_valid),
    .last_id   (last_id),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Beat acceptance is combinational so fifo_full gates the push in the same cycle.
  assign beat      = (state == ARB_OWN) && req_valid[grant_id] && !fifo_full;
  assign fifo_push = beat;
  assign fifo_data = req_data[int'(grant_id)*DATA_W +: DATA_W];

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = beat;
  end

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] burst_cnt;

  assign last_beat = (burst_cnt == 4'(MAX_BURST - 1));

  // Frozen while the FIFO is full; cleared whenever ownership is re-decided.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (release_grant || state == ARB_IDLE) begin
      burst_cnt <= '0;
    end else if (beat) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  assign release_grant = (state == ARB_OWN) &&
                         (!req_valid[grant_id] || (beat && last_beat));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_id     <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            state       <= ARB_OWN;
            grant_valid <= 1'b1;
            grant_id    <= winner;
            last_id     <= winner;
          end
        end
        ARB_OWN: begin
          if (release_grant) begin
            if (any_valid) begin
              grant_id <= winner;
              last_id  <= winner;
            end else begin
              state       <= ARB_IDLE;
              grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= ARB_IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_count <= '0;
    end else if (fifo_push) begin
      push_count <= push_count + 1'b1;
    end
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the push side of one `fifo` instance (4-deep, 32-bit) among several producers. It sequences grants with a small state machine and drives the FIFO's `push`/`data_in`. It honours `fifo_full` back-pressure and optionally holds a grant for a bounded burst. It sits directly in front of the FIFO; the pop side is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 32: data width; must equal the FIFO's `fifo_width`.
- `MAX_BURST`, default 4: maximum beats per grant when burst mode is compiled in, 1..15.

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester data-valid.
- `req_data`  in  NUM_REQ*DATA_W  flattened request data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  per-requester beat accepted this cycle.
- `fifo_full`  in  1  from the FIFO.
- `fifo_push`  out  1  to the FIFO's `push`.
- `fifo_data`  out  DATA_W  to the FIFO's `data_in`.
- `grant_valid`  out  1  a requester currently owns the FIFO.
- `grant_id`  out  $clog2(NUM_REQ)  current owner index.
- `push_count`  out  16  total accepted beats; wraps at 2^16.

## Operation
- FSM states: `ARB_IDLE` (no owner) and `ARB_OWN` (owner registered in `grant_id`).
- Winner selection: the first set `req_valid` bit searching upward from `last_id+1`, wrapping modulo NUM_REQ. `last_id` is the most recently granted index.
- `ARB_IDLE`: if any `req_valid` is set, register the winner into `grant_id` and `last_id`, then go to `ARB_OWN`. Otherwise stay.
- `ARB_OWN`, beat acceptance (combinational):
  - `beat = req_valid[grant_id] && !fifo_full`.
  - `fifo_push = beat`.
  - `req_ready[grant_id] = beat`; all other `req_ready` bits are 0.
  - `fifo_data = req_data` slice of `grant_id`, always driven.
- Release condition in `ARB_OWN`:
  - the owner drops `req_valid`; or
  - an accepted beat is the last allowed, which depends on the Configuration macro.
- On release, the next winner is computed in the same cycle from the current `req_valid`, excluding nothing, so the owner may re-win only if it is the sole requester. The next winner is registered with no idle bubble. If no request is valid, go to `ARB_IDLE`.
- `fifo_full` high: no beat is accepted, the grant is held, and the burst counter is frozen. A full FIFO never causes release.
- `push_count` increments by 1 on every `fifo_push`.

## Timing
- Reset values:
  - state `ARB_IDLE`, `grant_valid`=0, `grant_id`=0.
  - `last_id`=NUM_REQ-1, so requester 0 wins first.
  - burst counter 0, `push_count`=0.
  - `fifo_push`=0, `req_ready`=0.
- Request to first accepted beat: 1 cycle. `req_valid` seen in `ARB_IDLE` at edge n gives a grant at n+1, and `fifo_push` can be high in cycle n+1.
- Back-to-back grants: zero bubble between owners.
- `fifo_full` to `fifo_push` is purely combinational. `fifo_push` is never high while `fifo_full` is high.
- Data must be held stable by a requester while `req_valid` is high and `req_ready` is low.
- Reset mid-burst: everything returns to the reset values immediately; any partially sent burst is abandoned. Requesters re-present their data.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - a 4-bit burst counter counts accepted beats of the current owner.
  - release occurs when the count reaches MAX_BURST or the owner drops `req_valid`.
  - the counter clears on every new grant.
- Not defined:
  - release after every accepted beat (MAX_BURST is ignored), giving strict per-beat round-robin.
  - the burst counter logic is absent.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_OWN`).
  - `PUSH_CNT_W`=16.
  - a `function` returning the ID width for a given NUM_REQ.
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs are the request vector and `last_id`; outputs are winner index and any-valid.

## Test plan
- Single requester, no burst mode: after reset, `req_valid`=4'b0001 with data 0xA0..0xA3 → grant 1 cycle later, then one push per cycle. All 4 beats enter the FIFO and `push_count`=4.
- All four requesting continuously, burst mode off → `grant_id` sequence 0,1,2,3,0,... with one beat each and no idle cycles.
- Burst mode on, MAX_BURST=2, requesters 1 and 3 valid → beats from 1,1,3,3,1,1, and `grant_id` changes exactly after every 2nd beat.
- FIFO fills (4 beats, no pop) while requester 2 owns → `fifo_push`=0 and `req_ready`=0 while `fifo_full`=1, and the grant stays 2. The first pop resumes pushes from 2 in the same cycle `fifo_full` falls.
- Owner drops `req_valid` mid-burst while requester 0 waits → grant moves to 0 on the next edge with no bubble.
- Assert `reset` mid-burst → on the same edge, `grant_valid`=0 and `push_count`=0. The first grant after reset goes to the lowest-indexed valid requester.
